// File: rtl/sliding_window_stream.sv
// rtl/sliding_window_stream.sv - streaming KxK neighbourhood generator with KERNEL_SIZE-1 line buffers
// Window, centre and pulses are registered one cycle after the accepted pixel.
module sliding_window_stream #(
    parameter int DATA_WIDTH  = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int ROW_WIDTH   = 640,
    parameter int NUM_ROWS    = 480
) (
    input  logic                                                  clk,
    input  logic                                                  reset,
    input  logic                                                  in_valid,
    input  logic                                                  sof,
    input  logic [DATA_WIDTH-1:0]                                 pixel_in,
    output logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][DATA_WIDTH-1:0] window,
    output logic                                                  window_valid,
    output logic [$clog2(ROW_WIDTH)-1:0]                          center_x,
    output logic [$clog2(NUM_ROWS)-1:0]                           center_y,
    output logic                                                  frame_done
);

    localparam int CW   = $clog2(ROW_WIDTH);
    localparam int RW   = $clog2(NUM_ROWS);
    localparam int K    = KERNEL_SIZE;
    localparam int NL   = KERNEL_SIZE - 1;
    localparam int HALF = (KERNEL_SIZE - 1) / 2;

    localparam logic [CW-1:0] LAST_COL = CW'(ROW_WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(NUM_ROWS - 1);
    localparam logic [CW-1:0] K1_COL   = CW'(K - 1);
    localparam logic [RW-1:0] K1_ROW   = RW'(K - 1);
    localparam logic [CW-1:0] HALF_COL = CW'(HALF);
    localparam logic [RW-1:0] HALF_ROW = RW'(HALF);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [K-1:0][K-1:0][DATA_WIDTH-1:0] r_window;
    logic          r_valid;
    logic          r_done;
    logic [CW-1:0] r_cx;
    logic [RW-1:0] r_cy;

    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic          w_last_col;
    logic          w_last_row;
    logic          w_in_window;
    logic [DATA_WIDTH-1:0] w_line_rd [NL];
    logic [DATA_WIDTH-1:0] w_line_wr [NL];

    // sof forces the accepted pixel to (0,0) regardless of where the counters were
    assign w_col       = sof ? '0 : r_col;
    assign w_row       = sof ? '0 : r_row;
    assign w_last_col  = (w_col == LAST_COL);
    assign w_last_row  = (w_row == LAST_ROW);
    assign w_in_window = (w_row >= K1_ROW) && (w_col >= K1_COL);

    // Line g holds the pixel from K-1-g rows above the current one, per column.
    // Contents are never reset: validity gating only exposes rows written this frame.
    for (genvar g = 0; g < NL; g++) begin : g_line
        logic [DATA_WIDTH-1:0] r_mem [ROW_WIDTH];

        assign w_line_rd[g] = r_mem[w_col];

        if (g == NL - 1) begin : g_newest
            assign w_line_wr[g] = pixel_in;
        end else begin : g_older
            assign w_line_wr[g] = w_line_rd[g+1];
        end

        always_ff @(posedge clk) begin
            if (in_valid) begin
                r_mem[w_col] <= w_line_wr[g];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col    <= '0;
            r_row    <= '0;
            r_window <= '0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
            r_cx     <= '0;
            r_cy     <= '0;
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            if (in_valid) begin
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K - 1; c++) begin
                        r_window[r][c] <= r_window[r][c+1];
                    end
                end
                for (int r = 0; r < NL; r++) begin
                    r_window[r][K-1] <= w_line_rd[r];
                end
                r_window[K-1][K-1] <= pixel_in;

                r_valid <= w_in_window;
                r_done  <= w_last_col && w_last_row;
                r_cx    <= w_col - HALF_COL;
                r_cy    <= w_row - HALF_ROW;

                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= w_last_row ? '0 : w_row + 1'b1;
                end else begin
                    r_col <= w_col + 1'b1;
                    r_row <= w_row;
                end
            end
        end
    end

    assign window       = r_window;
    assign window_valid = r_valid;
    assign frame_done   = r_done;
    assign center_x     = r_cx;
    assign center_y     = r_cy;

endmodule

// File: tb/tb_sliding_window_stream.sv
// tb/tb_sliding_window_stream.sv - bench for sliding_window_stream
// Two instances: K=3 on a 5x5 frame and K=5 on a 10x8 frame with 12-bit pixels.
module tb_sliding_window_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic                 a_valid, a_sof;
    logic [7:0]           a_pix;
    logic [2:0][2:0][7:0] a_win;
    logic                 a_wv, a_done;
    logic [2:0]           a_cx, a_cy;

    logic                  b_valid, b_sof;
    logic [11:0]           b_pix;
    logic [4:0][4:0][11:0] b_win;
    logic                  b_wv, b_done;
    logic [3:0]            b_cx;
    logic [2:0]            b_cy;

    int vectors = 0;
    int errors  = 0;

    sliding_window_stream #(
        .DATA_WIDTH(8), .KERNEL_SIZE(3), .ROW_WIDTH(5), .NUM_ROWS(5)
    ) dut_a (
        .clk(clk), .reset(rst), .in_valid(a_valid), .sof(a_sof), .pixel_in(a_pix),
        .window(a_win), .window_valid(a_wv), .center_x(a_cx), .center_y(a_cy),
        .frame_done(a_done)
    );

    sliding_window_stream #(
        .DATA_WIDTH(12), .KERNEL_SIZE(5), .ROW_WIDTH(10), .NUM_ROWS(8)
    ) dut_b (
        .clk(clk), .reset(rst), .in_valid(b_valid), .sof(b_sof), .pixel_in(b_pix),
        .window(b_win), .window_valid(b_wv), .center_x(b_cx), .center_y(b_cy),
        .frame_done(b_done)
    );

    // Reference model for the K=3 instance: the frame image is kept as a 2D array
    // and each window is cut straight out of it.
    int  ma_img [5][5];
    int  ma_r = 0, ma_c = 0;
    int  ea_win [3][3];
    bit  ea_valid = 0, ea_done = 0, ea_known = 0;
    int  ea_cx = 0, ea_cy = 0;
    int  a_vcnt = 0, a_dcnt = 0;

    task automatic model_a(input bit s, input int p);
        int r, c;
        r = s ? 0 : ma_r;
        c = s ? 0 : ma_c;
        ma_img[r][c] = p;
        ea_valid = (r >= 2) && (c >= 2);
        ea_done  = (r == 4) && (c == 4);
        if (ea_valid) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    ea_win[i][j] = ma_img[r-2+i][c-2+j];
            ea_cx = c - 1;
            ea_cy = r - 1;
        end
        ea_known = ea_valid;
        c++;
        if (c == 5) begin
            c = 0;
            r = (r == 4) ? 0 : r + 1;
        end
        ma_r = r;
        ma_c = c;
    endtask

    task automatic a_beat(input bit v, input bit s, input int p);
        a_valid = v;
        a_sof   = s;
        a_pix   = 8'(p);
        if (v) model_a(s, p);
        else begin
            ea_valid = 0;
            ea_done  = 0;
        end
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        a_sof   = 1'b0;
        vectors++;
        if (a_wv !== ea_valid) begin
            errors++;
            $display("FAIL a_window_valid (pix %0d): got %0b want %0b", p, a_wv, ea_valid);
        end
        vectors++;
        if (a_done !== ea_done) begin
            errors++;
            $display("FAIL a_frame_done (pix %0d): got %0b want %0b", p, a_done, ea_done);
        end
        if (ea_known) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) begin
                    vectors++;
                    if (a_win[i][j] !== 8'(ea_win[i][j])) begin
                        errors++;
                        $display("FAIL a_window[%0d][%0d] (pix %0d): got %0d want %0d",
                                 i, j, p, a_win[i][j], ea_win[i][j]);
                    end
                end
            vectors++;
            if (a_cx !== 3'(ea_cx) || a_cy !== 3'(ea_cy)) begin
                errors++;
                $display("FAIL a_center (pix %0d): got (%0d,%0d) want (%0d,%0d)",
                         p, a_cx, a_cy, ea_cx, ea_cy);
            end
        end
        if (a_wv === 1'b1) a_vcnt++;
        if (a_done === 1'b1) a_dcnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (a_wv !== 1'b0 || a_done !== 1'b0 || a_win !== '0 || a_cx !== '0 || a_cy !== '0) begin
            errors++;
            $display("FAIL reset_a: got wv=%0b done=%0b cx=%0d cy=%0d win=%h want all zero",
                     a_wv, a_done, a_cx, a_cy, a_win);
        end
        vectors++;
        if (b_wv !== 1'b0 || b_done !== 1'b0 || b_win !== '0 || b_cx !== '0 || b_cy !== '0) begin
            errors++;
            $display("FAIL reset_b: got wv=%0b done=%0b cx=%0d cy=%0d want all zero",
                     b_wv, b_done, b_cx, b_cy);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_fill();
        int first_w [3][3] = '{'{1, 2, 3}, '{6, 7, 8}, '{11, 12, 13}};
        int last_w  [3][3] = '{'{13, 14, 15}, '{18, 19, 20}, '{23, 24, 25}};
        a_vcnt = 0;
        a_dcnt = 0;
        for (int p = 1; p <= 25; p++) begin
            a_beat(1'b1, p == 1, p);
            if (p == 13 || p == 25) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++) begin
                        vectors++;
                        if (a_win[i][j] !== 8'((p == 13) ? first_w[i][j] : last_w[i][j])) begin
                            errors++;
                            $display("FAIL fill_window_%0d[%0d][%0d]: got %0d want %0d", p, i, j,
                                     a_win[i][j], (p == 13) ? first_w[i][j] : last_w[i][j]);
                        end
                    end
            end
            if (p == 16 || p == 17) begin
                vectors++;
                if (a_wv !== 1'b0) begin
                    errors++;
                    $display("FAIL row_straddle_%0d: got valid %0b want 0", p, a_wv);
                end
            end
            if (p == 18) begin
                vectors++;
                if (a_wv !== 1'b1 || a_cx !== 3'd1 || a_cy !== 3'd2) begin
                    errors++;
                    $display("FAIL row_boundary_18: got v=%0b (%0d,%0d) want v=1 (1,2)", a_wv, a_cx, a_cy);
                end
            end
        end
        vectors++;
        if (a_vcnt !== 9 || a_dcnt !== 1) begin
            errors++;
            $display("FAIL fill_counts: got valid=%0d done=%0d want 9 and 1", a_vcnt, a_dcnt);
        end
    endtask

    task automatic test_bubbles();
        a_vcnt = 0;
        a_dcnt = 0;
        for (int p = 1; p <= 25; p++) begin
            a_beat(1'b1, p == 1, p);
            a_beat(1'b0, 1'b0, 0);
        end
        vectors++;
        if (a_vcnt !== 9 || a_dcnt !== 1) begin
            errors++;
            $display("FAIL bubble_counts: got valid=%0d done=%0d want 9 and 1", a_vcnt, a_dcnt);
        end
    endtask

    task automatic test_sof_mid_frame();
        int  first_w [3][3] = '{'{101, 102, 103}, '{106, 107, 108}, '{111, 112, 113}};
        bit  seen = 0;
        a_vcnt = 0;
        a_dcnt = 0;
        for (int p = 1; p <= 8; p++) a_beat(1'b1, p == 1, p);
        for (int v = 101; v <= 125; v++) begin
            a_beat(1'b1, v == 101, v);
            if (a_wv === 1'b1 && !seen) begin
                seen = 1;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++) begin
                        vectors++;
                        if (a_win[i][j] !== 8'(first_w[i][j])) begin
                            errors++;
                            $display("FAIL sof_first_window[%0d][%0d]: got %0d want %0d",
                                     i, j, a_win[i][j], first_w[i][j]);
                        end
                    end
            end
        end
        vectors++;
        if (a_dcnt !== 1 || a_vcnt !== 9) begin
            errors++;
            $display("FAIL sof_counts: got done=%0d valid=%0d want 1 and 9", a_dcnt, a_vcnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int p = 1; p <= 14; p++) a_beat(1'b1, p == 1, p);
        #3;
        rst = 1'b1;
        #1;
        vectors++;
        if (a_wv !== 1'b0 || a_done !== 1'b0 || a_win !== '0 || a_cx !== '0 || a_cy !== '0) begin
            errors++;
            $display("FAIL async_reset: got wv=%0b done=%0b cx=%0d cy=%0d win=%h want all zero",
                     a_wv, a_done, a_cx, a_cy, a_win);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        ma_r = 0;
        ma_c = 0;
        ea_known = 0;
        a_vcnt = 0;
        a_dcnt = 0;
        for (int p = 1; p <= 25; p++) a_beat(1'b1, 1'b0, p);
        vectors++;
        if (a_vcnt !== 9 || a_dcnt !== 1) begin
            errors++;
            $display("FAIL post_reset_counts: got valid=%0d done=%0d want 9 and 1", a_vcnt, a_dcnt);
        end
    endtask

    task automatic test_random_frames();
        for (int n = 0; n < 120; n++) begin
            bit v, s;
            v = ($urandom_range(0, 3) != 0);
            s = v && (n == 0 || $urandom_range(0, 39) == 0);
            a_beat(v, s, int'($urandom_range(0, 255)));
        end
    endtask

    task automatic test_generalised();
        int vcnt = 0, dcnt = 0;
        bit first = 1;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 10; c++) begin
                bit ev;
                b_valid = 1'b1;
                b_sof   = (r == 0 && c == 0);
                b_pix   = 12'(100 * r + c);
                ev = (r >= 4) && (c >= 4);
                @(posedge clk);
                #1;
                b_valid = 1'b0;
                b_sof   = 1'b0;
                vectors++;
                if (b_wv !== ev || b_done !== (r == 7 && c == 9)) begin
                    errors++;
                    $display("FAIL gen_flags (%0d,%0d): got v=%0b d=%0b want v=%0b d=%0b",
                             r, c, b_wv, b_done, ev, (r == 7 && c == 9));
                end
                if (ev) begin
                    for (int i = 0; i < 5; i++)
                        for (int j = 0; j < 5; j++) begin
                            vectors++;
                            if (b_win[i][j] !== 12'(100 * (r - 4 + i) + (c - 4 + j))) begin
                                errors++;
                                $display("FAIL gen_window[%0d][%0d] (%0d,%0d): got %0d want %0d",
                                         i, j, r, c, b_win[i][j], 100 * (r - 4 + i) + (c - 4 + j));
                            end
                        end
                    vectors++;
                    if (b_cx !== 4'(c - 2) || b_cy !== 3'(r - 2)) begin
                        errors++;
                        $display("FAIL gen_center (%0d,%0d): got (%0d,%0d) want (%0d,%0d)",
                                 r, c, b_cx, b_cy, c - 2, r - 2);
                    end
                end
                if (b_wv === 1'b1 && first) begin
                    first = 0;
                    vectors++;
                    if (b_win[0][0] !== 12'd0 || b_win[4][4] !== 12'd404 ||
                        b_cx !== 4'd2 || b_cy !== 3'd2) begin
                        errors++;
                        $display("FAIL gen_first: got w00=%0d w44=%0d c=(%0d,%0d) want 0 404 (2,2)",
                                 b_win[0][0], b_win[4][4], b_cx, b_cy);
                    end
                end
                if (b_wv === 1'b1) vcnt++;
                if (b_done === 1'b1) dcnt++;
            end
        end
        vectors++;
        if (vcnt !== 24 || dcnt !== 1) begin
            errors++;
            $display("FAIL gen_counts: got valid=%0d done=%0d want 24 and 1", vcnt, dcnt);
        end
    endtask

    initial begin
        rst     = 1'b1;
        a_valid = 1'b0;
        a_sof   = 1'b0;
        a_pix   = '0;
        b_valid = 1'b0;
        b_sof   = 1'b0;
        b_pix   = '0;
        test_reset();
        test_basic_fill();
        test_bubbles();
        test_sof_mid_frame();
        test_reset_mid_frame();
        test_random_frames();
        test_generalised();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
